// File: rtl/teclado_pkg.sv
// teclado_pkg: shared types and constants for the 4x4 keypad scanner.
// Holds the scanner FSM state encoding, the raw key codes consumed by the
// keypad decoder and the column/row to code mapping.
package teclado_pkg;

    // Scanner FSM states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    // Raw key codes: {col[0], col[1], ~row[0], ~row[1]}
    localparam logic [3:0] KEY_1    = 4'b0011;
    localparam logic [3:0] KEY_2    = 4'b1011;
    localparam logic [3:0] KEY_3    = 4'b0111;
    localparam logic [3:0] KEY_A    = 4'b1111;
    localparam logic [3:0] KEY_4    = 4'b0001;
    localparam logic [3:0] KEY_5    = 4'b1001;
    localparam logic [3:0] KEY_6    = 4'b0101;
    localparam logic [3:0] KEY_B    = 4'b1101;
    localparam logic [3:0] KEY_7    = 4'b0010;
    localparam logic [3:0] KEY_8    = 4'b1010;
    localparam logic [3:0] KEY_9    = 4'b0110;
    localparam logic [3:0] KEY_C    = 4'b1110;
    localparam logic [3:0] KEY_STAR = 4'b0000;
    localparam logic [3:0] KEY_0    = 4'b1000;
    localparam logic [3:0] KEY_HASH = 4'b0100;
    localparam logic [3:0] KEY_D    = 4'b1100;

    // Map a (column, row) position of the keypad to its raw key code
    function automatic logic [3:0] col_row_to_code(input logic [1:0] col,
                                                   input logic [1:0] row);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = KEY_0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: parameterized-width two-flop synchronizer for signals
// that arrive asynchronously to clk. Each bit is synchronized independently,
// so multi-bit inputs must tolerate per-bit skew (keypad rows do).
module sincronizador_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Two-stage capture chain resolving metastability on the first stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/teclado_barrido.sv
// teclado_barrido: 4x4 matrix keypad scanner.
// Drives one column low at a time, reads the synchronized rows, debounces
// press and release, and hands the raw key code plus a one-cycle strobe to
// the keypad decoder. key_held stays high until the release is debounced.
// Optional build macro: TECLADO_REPEAT_EN adds auto-repeat strobes every
// REPEAT_CYCLES cycles while the accepted key remains held.
module teclado_barrido
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       rows_s;
    logic             rows_idle;
    logic             scan_tick;
    logic [1:0]       row_low;

    estado_t          state_reg,    state_next;
    logic [1:0]       col_reg,      col_next;
    logic [1:0]       row_reg,      row_next;
    logic [DIV_W-1:0] div_cnt_reg,  div_cnt_next;
    logic [DEB_W-1:0] deb_cnt_reg,  deb_cnt_next;
    logic [3:0]       key_code_reg, key_code_next;
    logic             key_valid_reg, key_valid_next;
    logic             key_held_reg, key_held_next;

`ifdef TECLADO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
`else
    // Repeat interval has no effect in this build; referenced only so the
    // parameter list stays identical across builds.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYCLES > 0);
`endif

    // Rows idle high (no key) out of reset so nothing is detected spuriously
    sincronizador_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_sync_rows (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rows_n),
        .q     (rows_s)
    );

    assign rows_idle = (rows_s == 4'b1111);
    assign scan_tick = (state_reg == SCAN) && (div_cnt_reg == DIV_LAST);

    // One-hot active-low column drive decoded from the current column
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_cols
        assign cols_n[gi] = (col_reg != 2'(gi));
    end

    // Lowest-index low row wins when several rows are pressed together
    always_comb begin
        row_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) row_low = 2'(i);
        end
    end

    // Scanner FSM next-state, counters and output register updates
    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        div_cnt_next   = div_cnt_reg;
        deb_cnt_next   = deb_cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        key_held_next  = key_held_reg;
`ifdef TECLADO_REPEAT_EN
        rep_cnt_next   = rep_cnt_reg;
`endif
        case (state_reg)
            SCAN: begin
                if (scan_tick) begin
                    div_cnt_next = '0;
                    if (rows_idle) begin
                        col_next = col_reg + 2'd1;
                    end else begin
                        row_next   = row_low;
                        state_next = DEBOUNCE;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (rows_s[row_reg]) begin
                    // Press bounced away: resume scanning on the same column
                    deb_cnt_next = '0;
                    state_next   = SCAN;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_cnt_next   = '0;
                    key_code_next  = col_row_to_code(col_reg, row_reg);
                    key_valid_next = 1'b1;
                    key_held_next  = 1'b1;
                    state_next     = PRESSED;
`ifdef TECLADO_REPEAT_EN
                    rep_cnt_next   = '0;
`endif
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
            end
            PRESSED: begin
                deb_cnt_next = '0;
                state_next   = RELEASE;
`ifdef TECLADO_REPEAT_EN
                // The PRESSED cycle counts towards the first repeat interval
                rep_cnt_next = rep_cnt_reg + REP_W'(1);
`endif
            end
            RELEASE: begin
                if (!rows_idle) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_cnt_next  = '0;
                    key_held_next = 1'b0;
                    col_next      = col_reg + 2'd1;
                    state_next    = SCAN;
                end else begin
                    deb_cnt_next = deb_cnt_reg + DEB_W'(1);
                end
`ifdef TECLADO_REPEAT_EN
                if (rows_idle) begin
                    rep_cnt_next = '0;
                end else if (rep_cnt_reg == REP_LAST) begin
                    rep_cnt_next   = '0;
                    key_valid_next = 1'b1;
                end else begin
                    rep_cnt_next = rep_cnt_reg + REP_W'(1);
                end
`endif
            end
            default: state_next = SCAN;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            row_reg       <= 2'd0;
            div_cnt_reg   <= '0;
            deb_cnt_reg   <= '0;
            key_code_reg  <= 4'b0000;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
`ifdef TECLADO_REPEAT_EN
            rep_cnt_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            div_cnt_reg   <= div_cnt_next;
            deb_cnt_reg   <= deb_cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_held_reg  <= key_held_next;
`ifdef TECLADO_REPEAT_EN
            rep_cnt_reg   <= rep_cnt_next;
`endif
        end
    end

    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_teclado_barrido.sv
// tb_teclado_barrido: directed bench for the keypad scanner.
// A behavioural keypad pulls a row low whenever a pressed key sits in the
// column currently driven low. Timing references: t_low is the cycle the
// key's row first reads low on the pins; the strobe lands 12 cycles later
// (3 to the scan tick, 8 debounce, 1 into PRESSED). A release applied at
// cycle t_rel drops key_held at t_rel+10 (2 sync + 8 debounce).
module tb_teclado_barrido;

    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int REP  = 32;
`ifdef TECLADO_REPEAT_EN
    localparam int D_STROBES = 4;
`else
    localparam int D_STROBES = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  rows_n;
    logic [3:0]  cols_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;       // bit col*4+row
    int          cyc;
    int          n_vec;
    int          n_err;
    logic        prev_valid;
    int          s_cyc[$];
    logic [3:0]  s_code[$];

    teclado_barrido #(
        .SCAN_DIV        (SCAN),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows_n    (rows_n),
        .cols_n    (cols_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix model
    always_comb begin
        rows_n = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !cols_n[c]) rows_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Strobe monitor: one line per strobe, no back-to-back strobes allowed
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            chk("valid_gap", 32'(prev_valid), 32'(0));
            s_cyc.push_back(cyc);
            s_code.push_back(key_code);
            $display("strobe cyc=%0d code=%b held=%b", cyc, key_code, key_held);
        end
        prev_valid <= key_valid;
    end

    task automatic tick_to(input int t);
        int n = 0;
        while (cyc < t && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Wait until the column before 'col' is driven, so the key's column
    // becomes active cleanly after the press
    task automatic arm(input string tag, input int col);
        logic [3:0] want;
        int n = 0;
        want = ~(4'b0001 << ((col + 3) % 4));
        while (cols_n !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arm"}, 32'(cols_n), 32'(want));
    endtask

    task automatic wait_low(input string tag, input logic [3:0] exp_rows, output int t_low);
        int n = 0;
        while (rows_n === 4'b1111 && n < 64) begin
            @(negedge clk);
            n++;
        end
        t_low = cyc;
        chk({tag, "_rows"}, 32'(rows_n), 32'(exp_rows));
    endtask

    task automatic wait_fall(input string tag, input int t_rel);
        int n = 0;
        while (key_held === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_held_fall"}, 32'(cyc), 32'(t_rel + 10));
    endtask

    task automatic check_strobes(input string tag, input int base, input int first,
                                 input int exp_n, input logic [3:0] exp_code);
        chk({tag, "_count"}, 32'(s_cyc.size() - base), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (base + i < s_cyc.size()) begin
                chk({tag, "_cyc"}, 32'(s_cyc[base+i]), 32'(first + REP*i));
                chk({tag, "_code"}, 32'(s_code[base+i]), 32'(exp_code));
            end
        end
    endtask

    // Press one key (or two in the same column when row2 >= 0), hold it for
    // 'hold' cycles after t_low, release, then check strobes and key_held
    task automatic run_key(input string tag, input int col, input int row, input int row2,
                           input int hold, input int exp_n, input logic [3:0] exp_code);
        int base, t_low, t_rel;
        logic [3:0] exp_rows;
        exp_rows = ~(4'b0001 << row);
        arm(tag, col);
        base = s_cyc.size();
        pressed[col*4+row] = 1'b1;
        if (row2 >= 0) begin
            pressed[col*4+row2] = 1'b1;
            exp_rows = exp_rows & ~(4'b0001 << row2);
        end
        wait_low(tag, exp_rows, t_low);
        tick_to(t_low + hold);
        chk({tag, "_held"}, 32'(key_held), 32'(1));
        pressed = '0;
        t_rel = cyc;
        wait_fall(tag, t_rel);
        check_strobes(tag, base, t_low + 12, exp_n, exp_code);
    endtask

    initial begin
        int base, t_low, t_rel;
        logic [3:0] sweep_codes [16];
        sweep_codes = '{4'b0011, 4'b1011, 4'b0111, 4'b1111,
                        4'b0001, 4'b1001, 4'b0101, 4'b1101,
                        4'b0010, 4'b1010, 4'b0110, 4'b1110,
                        4'b0000, 4'b1000, 4'b0100, 4'b1100};
        n_vec = 0;
        n_err = 0;
        cyc = 0;
        prev_valid = 1'b0;
        pressed = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cols", 32'(cols_n), 32'(4'b1110));
        chk("rst_code", 32'(key_code), 32'(0));
        chk("rst_valid", 32'(key_valid), 32'(0));
        chk("rst_held", 32'(key_held), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: clean press of 5
        run_key("key5", 1, 1, -1, 40, 1, 4'b1001);

        // 2: short bounce on key 7 is dropped and scanning resumes
        arm("bounce", 0);
        base = s_cyc.size();
        pressed[2] = 1'b1;
        wait_low("bounce", 4'b1011, t_low);
        tick_to(t_low + 4);
        pressed = '0;
        tick_to(t_low + 10);
        chk("bounce_col0", 32'(cols_n), 32'(4'b1110));
        tick_to(t_low + 11);
        chk("bounce_col1", 32'(cols_n), 32'(4'b1101));
        tick_to(t_low + 15);
        chk("bounce_col2", 32'(cols_n), 32'(4'b1011));
        tick_to(t_low + 40);
        chk("bounce_count", 32'(s_cyc.size() - base), 32'(0));
        chk("bounce_held", 32'(key_held), 32'(0));

        // 3: keys 3 and 9 together in column 2 -> lowest row (key 3)
        run_key("two_keys", 2, 0, 2, 20, 1, 4'b0111);

        // 4: long hold of D
        run_key("hold_d", 3, 3, -1, 120, D_STROBES, 4'b1100);

        // 5: release bounce after accepting 8
        arm("rel_bounce", 1);
        base = s_cyc.size();
        pressed[6] = 1'b1;
        wait_low("rel_bounce", 4'b1011, t_low);
        tick_to(t_low + 20);
        pressed[6] = 1'b0;
        tick_to(t_low + 23);
        pressed[6] = 1'b1;
        tick_to(t_low + 26);
        pressed[6] = 1'b0;
        tick_to(t_low + 29);
        pressed[6] = 1'b1;
        tick_to(t_low + 32);
        chk("rel_bounce_held", 32'(key_held), 32'(1));
        pressed = '0;
        t_rel = cyc;
        wait_fall("rel_bounce", t_rel);
        check_strobes("rel_bounce", base, t_low + 12, 1, 4'b1010);

        // 6: reset in the middle of DEBOUNCE
        arm("rst_mid", 0);
        base = s_cyc.size();
        pressed[1] = 1'b1;
        wait_low("rst_mid", 4'b1101, t_low);
        tick_to(t_low + 6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_cols", 32'(cols_n), 32'(4'b1110));
        chk("rst_mid_code", 32'(key_code), 32'(0));
        chk("rst_mid_valid", 32'(key_valid), 32'(0));
        chk("rst_mid_held", 32'(key_held), 32'(0));
        pressed = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_mid_count", 32'(s_cyc.size() - base), 32'(0));
        chk("rst_mid_code2", 32'(key_code), 32'(0));

        // Sweep all 16 keys in table order
        for (int k = 0; k < 16; k++) begin
            run_key($sformatf("sweep%0d", k), k % 4, k / 4, -1, 20, 1, sweep_codes[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
